// File: rtl/if_id_pipe_reg_pkg.sv
// Shared CPU pipeline definitions: default widths, the NOP encoding,
// the pipeline-register control decode and the stall-run counter states.
package if_id_pipe_reg_pkg;

    localparam int unsigned DEF_ADDR_W  = 64;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam logic [31:0] NOP_INSTR   = 32'hD503201F;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } pipe_ctl_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_SAT      = 2'd2
    } cnt_state_t;

    // Flush wins over stall: a taken branch squashes even a stalled slot.
    function automatic pipe_ctl_t decode_ctl(input logic flush, input logic stall);
        pipe_ctl_t ctl;
        if (flush) begin
            ctl = FLUSH;
        end else if (stall) begin
            ctl = HOLD;
        end else begin
            ctl = LOAD;
        end
        return ctl;
    endfunction

endpackage

// File: rtl/if_id_pipe_reg_en_dff.sv
// Single-bit enable flip-flop: 2:1 hold/load mux feeding a D flop with
// asynchronous active-high reset to a parameterised value.
module en_dff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    // Select new data when enabled, otherwise recirculate the stored bit.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // Storage flop with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: captures fetched PC/instruction, holds on stall,
// inserts a NOP bubble on flush, and counts consecutive stall cycles.
module if_id_pipe_reg #(
    parameter int unsigned ADDR_W  = if_id_pipe_reg_pkg::DEF_ADDR_W,
    parameter int unsigned INSTR_W = if_id_pipe_reg_pkg::DEF_INSTR_W,
    parameter int unsigned CNT_W   = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = if_id_pipe_reg_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_run,
    output logic               stall_sat
);

    import if_id_pipe_reg_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    pipe_ctl_t          ctl_s;
    logic               pc_en_s;
    logic               slot_en_s;
    logic               valid_nxt_s;
    logic [INSTR_W-1:0] instr_nxt_s;

    // Decode control once, then form the flush-forcing mux level ahead of
    // the enable flops. PC only loads on LOAD; instruction/valid also
    // update on FLUSH so the bubble is written in.
    always_comb begin
        ctl_s       = decode_ctl(flush, stall);
        pc_en_s     = 1'b0;
        slot_en_s   = 1'b0;
        valid_nxt_s = 1'b0;
        instr_nxt_s = NOP_INSTR;
        case (ctl_s)
            LOAD: begin
                pc_en_s     = 1'b1;
                slot_en_s   = 1'b1;
                valid_nxt_s = in_valid;
                if (in_valid) begin
                    instr_nxt_s = in_instr;
                end else begin
                    instr_nxt_s = NOP_INSTR;
                end
            end
            HOLD: begin
                pc_en_s   = 1'b0;
                slot_en_s = 1'b0;
            end
            FLUSH: begin
                pc_en_s     = 1'b0;
                slot_en_s   = 1'b1;
                valid_nxt_s = 1'b0;
                instr_nxt_s = NOP_INSTR;
            end
            default: begin
                pc_en_s   = 1'b0;
                slot_en_s = 1'b0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_pc
            en_dff #(.RST_VAL(1'b0)) u_pc_bit (
                .clk   (clk),
                .reset (reset),
                .en    (pc_en_s),
                .d     (in_pc[gi]),
                .q     (out_pc[gi])
            );
        end
        for (gi = 0; gi < INSTR_W; gi++) begin : g_instr
            en_dff #(.RST_VAL(NOP_INSTR[gi])) u_instr_bit (
                .clk   (clk),
                .reset (reset),
                .en    (slot_en_s),
                .d     (instr_nxt_s[gi]),
                .q     (out_instr[gi])
            );
        end
    endgenerate

    en_dff #(.RST_VAL(1'b0)) u_valid_bit (
        .clk   (clk),
        .reset (reset),
        .en    (slot_en_s),
        .d     (valid_nxt_s),
        .q     (out_valid)
    );

    cnt_state_t       state_d;
    cnt_state_t       state_q;
    logic [CNT_W-1:0] stall_run_d;
    logic [CNT_W-1:0] stall_run_q;
    logic             stall_sat_d;
    logic             stall_sat_q;

    // Stall-run next state: count while holding, saturate at max, clear otherwise.
    always_comb begin
        state_d     = ST_IDLE;
        stall_run_d = '0;
        stall_sat_d = 1'b0;
        if (ctl_s == HOLD) begin
            case (state_q)
                ST_SAT: begin
                    state_d     = ST_SAT;
                    stall_run_d = CNT_MAX;
                end
                ST_IDLE, ST_COUNTING: begin
                    stall_run_d = stall_run_q + CNT_W'(1);
                    if (stall_run_d == CNT_MAX) begin
                        state_d = ST_SAT;
                    end else begin
                        state_d = ST_COUNTING;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    stall_run_d = '0;
                end
            endcase
        end else begin
            state_d     = ST_IDLE;
            stall_run_d = '0;
        end
        stall_sat_d = (stall_run_d == CNT_MAX);
    end

    // Stall-run state and its registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stall_run_q <= '0;
            stall_sat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_run_q <= stall_run_d;
            stall_sat_q <= stall_sat_d;
        end
    end

    assign stall_run = stall_run_q;
    assign stall_sat = stall_sat_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed self-checking bench for the IF/ID pipeline register.
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [3:0]  stall_run;
    logic        stall_sat;

    int total;
    int bad;

    if_id_pipe_reg dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .stall_run (stall_run),
        .stall_sat (stall_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [63:0] pc,
                           input logic [31:0] ins, input logic [3:0] run, input logic sat);
        chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".instr"}, {32'd0, out_instr}, {32'd0, ins});
        chk({tag, ".run"}, {60'd0, stall_run}, {60'd0, run});
        chk({tag, ".sat"}, {63'd0, stall_sat}, {63'd0, sat});
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_pc    = 64'd0;
        in_instr = 32'd0;

        // Power-on reset asserted before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk_all("por", 1'b0, 64'd0, NOP, 4'd0, 1'b0);
        step();
        reset = 1'b0;

        // Plain load.
        in_valid = 1'b1;
        in_pc    = 64'h40;
        in_instr = 32'h8B020020;
        step();
        chk_all("load", 1'b1, 64'h40, 32'h8B020020, 4'd0, 1'b0);

        // Hold for three edges while the fetch side moves on.
        stall    = 1'b1;
        in_pc    = 64'h44;
        in_instr = 32'h12345678;
        step();
        step();
        step();
        chk_all("hold3", 1'b1, 64'h40, 32'h8B020020, 4'd3, 1'b0);

        // Drop stall: counter clears, reload same slot contents.
        stall    = 1'b0;
        in_pc    = 64'h40;
        in_instr = 32'h8B020020;
        step();
        chk_all("unstall", 1'b1, 64'h40, 32'h8B020020, 4'd0, 1'b0);

        // Saturation over 20 stalled edges.
        stall    = 1'b1;
        in_pc    = 64'h99;
        in_instr = 32'hAAAA5555;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk_all("sat14", 1'b1, 64'h40, 32'h8B020020, 4'd14, 1'b0);
            if (i == 15) chk_all("sat15", 1'b1, 64'h40, 32'h8B020020, 4'd15, 1'b1);
            if (i == 20) chk_all("sat20", 1'b1, 64'h40, 32'h8B020020, 4'd15, 1'b1);
        end

        // Flush beats stall; PC is kept.
        flush = 1'b1;
        step();
        chk_all("flush_stall", 1'b0, 64'h40, NOP, 4'd0, 1'b0);

        // Bubble in: invalid fetch loads PC but forces NOP.
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        in_pc    = 64'h80;
        in_instr = 32'hFFFFFFFF;
        step();
        chk_all("bubble", 1'b0, 64'h80, NOP, 4'd0, 1'b0);

        // Load then flush without stall.
        in_valid = 1'b1;
        in_pc    = 64'hFFFF_0000_1234_5678;
        in_instr = 32'h0000_0001;
        step();
        chk_all("load2", 1'b1, 64'hFFFF_0000_1234_5678, 32'h0000_0001, 4'd0, 1'b0);
        flush = 1'b1;
        in_pc = 64'h1;
        step();
        chk_all("flush", 1'b0, 64'hFFFF_0000_1234_5678, NOP, 4'd0, 1'b0);

        // Reload, stall twice, then reset mid-cycle with stall still high.
        flush    = 1'b0;
        in_pc    = 64'h100;
        in_instr = 32'hCAFEF00D;
        step();
        stall = 1'b1;
        step();
        step();
        chk_all("prerst", 1'b1, 64'h100, 32'hCAFEF00D, 4'd2, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 64'd0, NOP, 4'd0, 1'b0);
        step();
        chk_all("rst_held", 1'b0, 64'd0, NOP, 4'd0, 1'b0);

        // First edge after release follows inputs (stall=1 -> HOLD).
        reset = 1'b0;
        step();
        chk_all("post_rst_hold", 1'b0, 64'd0, NOP, 4'd1, 1'b0);
        stall = 1'b0;
        step();
        chk_all("post_rst_load", 1'b1, 64'h100, 32'hCAFEF00D, 4'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Pipeline register between the fetch stage and the decode stage of the pipelined CPU.
- Captures the fetched instruction and its PC each cycle.
- Holds its contents on stall and replaces them with a NOP bubble on flush.
- Keeps a saturating count of consecutive stall cycles for hazard debug.
- Per-bit hold/load selection uses the team's 2:1 mux cell feeding a D flip-flop.

Parameters:
- ADDR_W, 64: PC width in bits.
- INSTR_W, 32: instruction width in bits.
- CNT_W, 4: width of the stall-run counter.
- NOP_INSTR, 32'hD503201F: encoding inserted on flush and reset.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- stall, input, 1: hold current contents (from the hazard unit).
- flush, input, 1: squash the current contents (from branch resolution).
- in_valid, input, 1: fetch stage holds a real instruction.
- in_pc, input, ADDR_W: PC of the fetched instruction.
- in_instr, input, INSTR_W: fetched instruction word.
- out_valid, output, 1: decode-stage instruction is real (not a bubble).
- out_pc, output, ADDR_W: registered PC.
- out_instr, output, INSTR_W: registered instruction.
- stall_run, output, CNT_W: consecutive stall cycles so far, saturating.
- stall_sat, output, 1: stall_run has reached its maximum value (2^CNT_W - 1).

Behaviour:
- Reset is asynchronous, active-high. While reset=1, independent of clk:
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR, stall_run=0, stall_sat=0.
- Latency: one cycle. Inputs present before edge N appear on the outputs after edge N.
- Priority at each rising edge is flush > stall > load:
  - LOAD (flush=0, stall=0): out_valid<=in_valid, out_pc<=in_pc, out_instr<=in_instr.
    - When in_valid=0, out_instr<=NOP_INSTR regardless of in_instr. out_pc still loads in_pc.
  - HOLD (flush=0, stall=1): all data outputs and out_valid keep their values.
  - FLUSH (flush=1, stall ignored): out_valid<=0, out_instr<=NOP_INSTR, out_pc keeps its value.
    - Flush with stall in the same cycle still flushes. This models a taken branch squashing a stalled slot.
- Stall-run counter state machine:
  - States: IDLE (stall_run=0), COUNTING (0 < stall_run < max), SAT (stall_run = max).
  - stall=1 and flush=0: stall_run increments. It saturates at 2^CNT_W - 1 and never wraps to 0.
  - stall=0 or flush=1: stall_run<=0, returning to IDLE.
  - stall_sat is registered together with stall_run, so it is high exactly when stall_run equals max.
- Reset asserted mid-stall clears everything immediately. After reset release, the first edge behaves as LOAD, HOLD or FLUSH according to the inputs.
- No combinational path from any input to any output. All outputs are flop-driven.
- Gate-level timing: flop clk-to-q plus 2:1 mux delay must fit within the CPU clock period used by the top-level bench.

Decomposition:
- Shared CPU package holds:
  - NOP_INSTR constant.
  - ADDR_W and INSTR_W defaults.
  - pipe_ctl_t enum {LOAD, HOLD, FLUSH}, decoded once from flush and stall.
- One natural sub-module: en_dff, a single-bit enable flip-flop.
  - 2:1 mux selects between q (hold) and d (load), feeding a D flip-flop with async reset.
  - Parameterised reset value, so NOP bits can reset to 1.
  - Instantiated ADDR_W+INSTR_W+1 times via generate.
- Flush forcing is a second mux level on the instruction and valid bits, ahead of en_dff.

Test Plan:
- Reset: assert reset mid-cycle with stall=1 -> outputs clear immediately without a clock edge: out_valid=0, out_pc=0, out_instr=D503201F, stall_run=0.
- Load: in_valid=1, in_pc=0x40, in_instr=0x8B020020, stall=0, flush=0, one edge -> out_valid=1, out_pc=0x40, out_instr=0x8B020020.
- Stall hold: after the load, set stall=1 for 3 edges while changing in_pc to 0x44 -> outputs stay at 0x40/0x8B020020, stall_run=3, stall_sat=0.
- Saturation: stall=1 for 20 edges -> stall_run reaches 15 at edge 15 and stays at 15, stall_sat=1. Dropping stall gives stall_run=0 after one edge.
- Flush priority: stall=1 and flush=1 with out_pc=0x40 -> after one edge out_valid=0, out_instr=D503201F, out_pc=0x40, stall_run=0.
- Bubble in: in_valid=0, in_instr=0xFFFFFFFF, stall=0, flush=0 -> out_valid=0, out_instr=D503201F, out_pc=in_pc.
